rf_access_sequencer: RTL and testbench
======================================

// Module: rf_access_sequencer
// PURPOSE
//  Sequences the single-address, registered-read register file through read/exec/writeback phases per instruction.
//  Drives rf address, write enable and the 3-bit phase code (001 read, 010 exec, 100 writeback, 000 idle).
//  Arbitrates the file's one port between the instruction pipeline and a debug read requester.
//  Flags execute timeouts and counts retired instructions.
// PARAMETERS
//  EXEC_TIMEOUT  64  max cycles in EXEC before abort (>=1)
//  CNT_W         32  width of retired-instruction counter
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst_n        in   1     asynchronous active-low reset
//  start        in   1     instruction request valid
//  ready        out  1     1 only in IDLE with no debug grant this cycle; start accepted when start&ready
//  rs1,rs2,rd   in   5 ea  register indices, latched on accept
//  use_rs2      in   1     latched; instruction reads rs2
//  writes_rd    in   1     latched; instruction writes rd
//  wb_sel       in   2     latched; 00 alu, 01 mem, 10 jal link
//  exec_done    in   1     execute unit result ready
//  dbg_req      in   1     debug read request
//  dbg_addr     in   5     debug register index
//  dbg_grant    out  1     debug read issued this cycle
//  dbg_valid    out  1     rf data is the debug result this cycle
//  rf_addr      out  5     register file address
//  rf_write     out  1     register file write enable
//  rf_phase     out  3     phase code to register file
//  rf_wb_sel    out  2     writeback source select (valid in WB)
//  rs1_valid    out  1     rf data holds rs1 this cycle
//  rs2_valid    out  1     rf data holds rs2 this cycle
//  busy         out  1     state != IDLE
//  done         out  1     one-cycle retire pulse
//  timeout_err  out  1     one-cycle abort pulse
//  retired_cnt  out  CNT_W saturating count of done pulses
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except ready=1; retired_cnt=0; no write issued. Reset mid-op aborts without writeback.
//  States: IDLE, RD1, RD2, EXEC, WB, DONE. Register file read data is valid the cycle after the address is driven.
//  IDLE: rf_phase=000. start&ready -> RD1. Else dbg_req -> dbg_grant=1, rf_addr=dbg_addr, rf_phase=001, stay IDLE.
//   dbg_valid=1 the following cycle. start has priority over dbg_req, which waits (dbg_grant=0).
//  RD1: rf_addr=rs1, rf_phase=001, rf_write=0. Next RD2 if use_rs2, else EXEC.
//  RD2: rf_addr=rs2, rf_phase=001; rs1_valid=1. Next EXEC.
//  EXEC: rf_phase=010. First EXEC cycle: rs2_valid=1 if use_rs2, else rs1_valid=1.
//   Timeout counter cleared on entry, +1 per cycle. exec_done -> WB if writes_rd && rd!=0, else DONE.
//   exec_done takes priority over timeout on the same cycle.
//   Counter reaching EXEC_TIMEOUT without exec_done -> timeout_err=1, -> DONE (no writeback, no count).
//  WB: rf_addr=rd, rf_write=1, rf_phase=100, rf_wb_sel=latched wb_sel; exactly one cycle. Next DONE.
//  DONE: rf_phase=000, done=1 (not after timeout); retired_cnt+1, saturating at all-ones. Next IDLE.
//  Writes to x0 are never issued (rd=0 skips WB).
//  Latched fields are immune to input changes after accept. start while busy is ignored (ready=0).
//  rf_write=1 only in WB. rf_phase is 001 only in RD1/RD2/debug grant.
//  Latency, start-to-done with exec_done immediate and writeback: 5 cycles (use_rs2=1), 4 (use_rs2=0).
// TESTING
//  R-type rs1=3,rs2=4,rd=5,exec_done in first EXEC -> addr 3,4,5 in RD1,RD2,WB; rf_write only in WB; done at T+5.
//  I-type use_rs2=0,rd=0,exec_done held -> no WB, rs1_valid in first EXEC, done at T+3, retired_cnt+1.
//  exec_done low for EXEC_TIMEOUT=4 cycles -> timeout_err pulse, no rf_write, retired_cnt unchanged, back to IDLE.
//  start and dbg_req same IDLE cycle -> instruction accepted, dbg_grant after DONE, dbg_valid next cycle with addr=dbg_addr.
//  Assert rst_n low in EXEC -> immediate IDLE, ready=1, no rf_write; next instruction completes normally.
//  Force retired_cnt to all-ones, retire one more -> stays all-ones.

Source files
------------

// File: rtl/rf_access_sequencer.sv
// Steps a single-port, registered-read register file through read/exec/writeback
// per instruction, sharing the port with debug reads while idle.
module rf_access_sequencer #(
  parameter int unsigned EXEC_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic             use_rs2,
  input  logic             writes_rd,
  input  logic [1:0]       wb_sel,
  input  logic             exec_done,
  input  logic             dbg_req,
  input  logic [4:0]       dbg_addr,
  output logic             dbg_grant,
  output logic             dbg_valid,
  output logic [4:0]       rf_addr,
  output logic             rf_write,
  output logic [2:0]       rf_phase,
  output logic [1:0]       rf_wb_sel,
  output logic             rs1_valid,
  output logic             rs2_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_EXEC, S_WB, S_DONE} state_e;

  localparam int unsigned     TW       = $clog2(EXEC_TIMEOUT) + 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(EXEC_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic             use_rs2_q, writes_rd_q;
  logic [1:0]       wb_sel_q;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             abort_q, abort_d;
  logic             dbg_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle, accept;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      use_rs2_q   <= 1'b0;
      writes_rd_q <= 1'b0;
      wb_sel_q    <= '0;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
      dbg_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
      dbg_valid_q <= dbg_grant;
      cnt_q       <= cnt_d;
      if (accept) begin
        rs1_q       <= rs1;
        rs2_q       <= rs2;
        rd_q        <= rd;
        use_rs2_q   <= use_rs2;
        writes_rd_q <= writes_rd;
        wb_sel_q    <= wb_sel;
      end
    end
  end

  // The EXEC cycle counter doubles as the "first EXEC cycle" marker (zero on entry).
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (accept) state_d = S_RD1;
      end
      S_RD1: begin
        tmo_d   = '0;
        state_d = use_rs2_q ? S_RD2 : S_EXEC;
      end
      S_RD2: begin
        tmo_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        tmo_d = tmo_q + TW'(1);
        if (exec_done) begin
          state_d = (writes_rd_q && (rd_q != '0)) ? S_WB : S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_DONE) && !abort_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    dbg_grant   = idle & dbg_req & ~start;
    ready       = idle & ~dbg_grant;
    dbg_valid   = dbg_valid_q;
    rf_addr     = '0;
    rf_write    = 1'b0;
    rf_phase    = 3'b000;
    rf_wb_sel   = '0;
    rs1_valid   = 1'b0;
    rs2_valid   = 1'b0;
    busy        = ~idle;
    done        = 1'b0;
    timeout_err = 1'b0;
    retired_cnt = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (dbg_grant) begin
          rf_addr  = dbg_addr;
          rf_phase = 3'b001;
        end
      end
      S_RD1: begin
        rf_addr  = rs1_q;
        rf_phase = 3'b001;
      end
      S_RD2: begin
        rf_addr   = rs2_q;
        rf_phase  = 3'b001;
        rs1_valid = 1'b1;
      end
      S_EXEC: begin
        rf_phase = 3'b010;
        if (tmo_q == '0) begin
          rs2_valid = use_rs2_q;
          rs1_valid = ~use_rs2_q;
        end
      end
      S_WB: begin
        rf_addr   = rd_q;
        rf_write  = 1'b1;
        rf_phase  = 3'b100;
        rf_wb_sel = wb_sel_q;
      end
      S_DONE: begin
        done        = ~abort_q;
        timeout_err = abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Bench for rf_access_sequencer: cycle-by-cycle comparison against a cycle-count
// reference model, directed vector table, reset/saturation sequences, random traffic.
module tb_rf_access_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, use_rs2 = 1'b0, writes_rd = 1'b0, exec_done = 1'b0, dbg_req = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0, dbg_addr = '0;
  logic [1:0] wb_sel = '0;
  logic       ready, dbg_grant, dbg_valid, rf_write, rs1_valid, rs2_valid, busy, done, timeout_err;
  logic [4:0] rf_addr;
  logic [2:0] rf_phase;
  logic [1:0] rf_wb_sel;
  logic [3:0] retired_cnt;

  rf_access_sequencer #(.EXEC_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .use_rs2(use_rs2), .writes_rd(writes_rd), .wb_sel(wb_sel),
    .exec_done(exec_done), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_grant(dbg_grant), .dbg_valid(dbg_valid), .rf_addr(rf_addr), .rf_write(rf_write),
    .rf_phase(rf_phase), .rf_wb_sel(rf_wb_sel), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready, dbg_grant, dbg_valid;
    logic [4:0] rf_addr;
    logic       rf_write;
    logic [2:0] rf_phase;
    logic [1:0] rf_wb_sel;
    logic       rs1_valid, rs2_valid, busy, done, timeout_err;
    logic [3:0] retired_cnt;
  } out_t;

  int n_pass = 0, n_total = 0;
  out_t obs;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
  endtask

  // Reference model: tracks cycles since accept (k) and derives the phase by arithmetic.
  bit         m_busy, m_use2, m_wr, m_over, m_abort, m_wb, m_dbgv;
  int         m_k, m_end, m_cnt;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [1:0] m_wbs;

  function automatic void model_reset();
    m_busy = 0; m_dbgv = 0; m_cnt = 0; m_over = 0; m_abort = 0; m_wb = 0; m_k = 0; m_end = 0;
  endfunction

  function automatic out_t model_expect();
    out_t e;
    int   reads;
    e = '0;
    e.dbg_valid   = m_dbgv;
    e.retired_cnt = 4'(m_cnt);
    e.busy        = m_busy;
    reads = m_use2 ? 2 : 1;
    if (!m_busy) begin
      if (start) e.ready = 1;
      else if (dbg_req) begin
        e.dbg_grant = 1; e.rf_addr = dbg_addr; e.rf_phase = 3'b001;
      end else e.ready = 1;
    end else if (m_k <= reads) begin
      e.rf_phase  = 3'b001;
      e.rf_addr   = (m_k == 1) ? m_rs1 : m_rs2;
      e.rs1_valid = (m_k == 2);
    end else if (!m_over) begin
      e.rf_phase  = 3'b010;
      e.rs2_valid = (m_k == reads + 1) && m_use2;
      e.rs1_valid = (m_k == reads + 1) && !m_use2;
    end else if (m_wb && (m_k - m_end == 1)) begin
      e.rf_addr = m_rd; e.rf_write = 1; e.rf_phase = 3'b100; e.rf_wb_sel = m_wbs;
    end else begin
      e.done = !m_abort; e.timeout_err = m_abort;
    end
    return e;
  endfunction

  function automatic void model_advance();
    int reads;
    reads = m_use2 ? 2 : 1;
    if (!m_busy) begin
      m_dbgv = !start && dbg_req;
      if (start) begin
        m_busy = 1; m_k = 1; m_over = 0; m_abort = 0; m_wb = 0;
        m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_use2 = use_rs2; m_wr = writes_rd; m_wbs = wb_sel;
      end
    end else begin
      m_dbgv = 0;
      if (m_k > reads && !m_over) begin
        if (exec_done) begin
          m_over = 1; m_end = m_k; m_wb = m_wr && (m_rd != 0);
        end else if (m_k - reads == TMO) begin
          m_over = 1; m_end = m_k; m_abort = 1; m_wb = 0;
        end
      end else if (m_over && !(m_wb && (m_k - m_end == 1))) begin
        if (!m_abort && m_cnt < 15) m_cnt++;
        m_busy = 0;
      end
      m_k++;
    end
  endfunction

  // Inputs are set just after a rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    out_t e;
    #1;
    if (!rst_n) model_reset();
    e = model_expect();
    obs = {ready, dbg_grant, dbg_valid, rf_addr, rf_write, rf_phase, rf_wb_sel,
           rs1_valid, rs2_valid, busy, done, timeout_err, retired_cnt};
    check("cycle", {9'd0, obs}, {9'd0, e});
    if (rst_n) model_advance();
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit use2, wr;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] wbs;
    int exec_on, dbg, exp_k, exp_tmo, exp_nwr, exp_delta;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    int done_k = -1, tmo_k = -1, grant_k = -1, dv_k = -1, nwr = 0, cnt0;
    logic [4:0] wr_addr = '0;
    cnt0 = m_cnt;
    for (int k = 0; k < 13; k++) begin
      start = (k == 0);
      if (k == 0) begin
        use_rs2 = v.use2; writes_rd = v.wr; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; wb_sel = v.wbs;
      end else begin
        use_rs2 = 1'($urandom); writes_rd = 1'($urandom); rs1 = 5'($urandom);
        rs2 = 5'($urandom); rd = 5'($urandom); wb_sel = 2'($urandom);
      end
      exec_done = (k >= v.exec_on);
      dbg_req   = (v.dbg != 0) && (grant_k < 0);
      dbg_addr  = 5'd17;
      tick();
      if (obs.done && done_k < 0) done_k = k;
      if (obs.timeout_err && tmo_k < 0) tmo_k = k;
      if (obs.dbg_grant && grant_k < 0) grant_k = k;
      if (obs.dbg_valid && dv_k < 0) dv_k = k;
      if (obs.rf_write) begin nwr++; wr_addr = obs.rf_addr; end
    end
    start = 0; dbg_req = 0;
    check($sformatf("v%0d_latency", idx), v.exp_tmo ? tmo_k : done_k, v.exp_k);
    if (v.exp_tmo) check($sformatf("v%0d_no_done", idx), done_k, -1);
    check($sformatf("v%0d_writes", idx), nwr, v.exp_nwr);
    if (v.exp_nwr > 0) check($sformatf("v%0d_wr_addr", idx), wr_addr, v.rd);
    check($sformatf("v%0d_cnt", idx), obs.retired_cnt, cnt0 + v.exp_delta);
    if (v.dbg != 0) begin
      check($sformatf("v%0d_grant_k", idx), grant_k, v.exp_k + 1);
      check($sformatf("v%0d_dvalid_k", idx), dv_k, v.exp_k + 2);
    end
  endtask

  task automatic short_instr(output int saw_done);
    saw_done = 0;
    start = 1; use_rs2 = 0; writes_rd = 0; rd = 5'd3; exec_done = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs.done) saw_done = 1;
    end
  endtask

  initial begin
    int nwr, sd;
    //        use2 wr  rs1    rs2    rd     wbs   exec dbg k tmo nwr delta
    vecs[0] = '{1, 1, 5'd3,  5'd4,  5'd5,  2'd1, 0,  0, 5, 0, 1, 1};
    vecs[1] = '{0, 1, 5'd6,  5'd0,  5'd0,  2'd0, 0,  0, 3, 0, 0, 1};
    vecs[2] = '{1, 1, 5'd1,  5'd2,  5'd8,  2'd2, 99, 0, 7, 1, 0, 0};
    vecs[3] = '{0, 1, 5'd10, 5'd0,  5'd7,  2'd0, 4,  0, 6, 0, 1, 1};
    vecs[4] = '{0, 0, 5'd11, 5'd0,  5'd12, 2'd0, 0,  1, 3, 0, 0, 1};
    vecs[5] = '{0, 1, 5'd13, 5'd0,  5'd9,  2'd2, 5,  0, 7, 0, 1, 1};
    vecs[6] = '{1, 0, 5'd14, 5'd15, 5'd16, 2'd1, 3,  0, 4, 0, 0, 1};

    model_reset();
    @(posedge clk); #1;
    tick();
    check("reset_ready", ready, 1);
    check("reset_cnt", retired_cnt, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset while in EXEC: abort without writeback, then a normal instruction.
    start = 1; use_rs2 = 1; writes_rd = 1; rs1 = 5'd3; rs2 = 5'd4; rd = 5'd5; exec_done = 0;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 0;
    tick();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", retired_cnt, 0);
    rst_n = 1;
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs.rf_write) nwr++;
    end
    check("rst_no_write", nwr, 0);
    run_vec(0, vecs[0]);

    // Saturation of the retired counter.
    for (int i = 0; i < 40 && m_cnt < 15; i++) short_instr(sd);
    check("sat_full", retired_cnt, 4'hF);
    short_instr(sd);
    check("sat_done", sd, 1);
    check("sat_hold", retired_cnt, 4'hF);

    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 3) == 0);
      use_rs2   = 1'($urandom);
      writes_rd = 1'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wb_sel    = 2'($urandom);
      exec_done = ($urandom_range(0, 3) == 0);
      dbg_req   = ($urandom_range(0, 2) == 0);
      dbg_addr  = 5'($urandom);
      tick();
    end
    rst_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

endmodule
